// File: rtl/gpio_scan_ctrl.sv
// Multiplexed row/digit scanner for the GPIO board, with time-shared LED/switch pins
// and a frame-rate switch debouncer. All outputs are registered (one cycle of latency).
module gpio_scan_ctrl #(
    parameter int NUM_ROWS     = 8,
    parameter int COL_W        = 16,
    parameter int SEG_W        = 8,
    parameter int IO_W         = 32,
    parameter int DWELL_CYCLES = 16384,
    parameter int BLANK_CYCLES = 2048,
    parameter int TRI_CYCLES   = 32,
    parameter int DEBOUNCE     = 3,
    parameter int COL_REVERSE  = 1,
    parameter int IO_REVERSE   = 1
) (
    input  logic                      clock_50,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_ROWS*COL_W-1:0] row_data,
    input  logic [NUM_ROWS*SEG_W-1:0] hex_data,
    input  logic [IO_W-1:0]           led_data,
    input  logic [IO_W-1:0]           gpio_in,
    output logic [NUM_ROWS-1:0]       row_out,
    output logic [COL_W-1:0]          col_out,
    output logic [SEG_W-1:0]          seg_out,
    output logic [IO_W-1:0]           led_out,
    output logic                      led_oe,
    output logic [IO_W-1:0]           sw_out,
    output logic                      sw_valid,
    output logic                      sw_changed,
    output logic                      frame_tick
);

    localparam int RW = $clog2(NUM_ROWS);
    localparam int DW = $clog2(DWELL_CYCLES);
    localparam int SW = $clog2(DEBOUNCE) + 1;

    localparam logic [DW-1:0] DWELL_LAST  = DW'(DWELL_CYCLES - 1);
    localparam logic [DW-1:0] BLANK_END   = DW'(BLANK_CYCLES);
    localparam logic [DW-1:0] BLANK_START = DW'(DWELL_CYCLES - BLANK_CYCLES);
    localparam logic [DW-1:0] TRI_END     = DW'(TRI_CYCLES);
    localparam logic [DW-1:0] SAMPLE_PT   = DW'(TRI_CYCLES / 2);
    localparam logic [RW-1:0] ROW_LAST    = RW'(NUM_ROWS - 1);
    localparam logic [SW-1:0] STABLE_MAX  = SW'(DEBOUNCE - 1);

    logic [DW-1:0]       dwell_cnt;
    logic [RW-1:0]       row_idx;
    logic [IO_W-1:0]     last_sample;
    logic [SW-1:0]       stable_cnt;

    logic                dwell_wrap;
    logic                row_wrap;
    logic                blank;
    logic                tri_win;
    logic                sample_hit;
    logic [NUM_ROWS-1:0] row_onehot;
    logic [COL_W-1:0]    col_slice;
    logic [COL_W-1:0]    col_next;
    logic [SEG_W-1:0]    seg_next;
    logic [IO_W-1:0]     led_next;
    logic [IO_W-1:0]     gpio_next;
    logic [IO_W-1:0]     last_next;
    logic [SW-1:0]       stable_next;
    logic                commit;

    always_comb begin
        dwell_wrap = (dwell_cnt == DWELL_LAST);
        row_wrap   = (row_idx == ROW_LAST);
        blank      = (dwell_cnt < BLANK_END) ||
                     ((BLANK_CYCLES != 0) && (dwell_cnt >= BLANK_START));
        tri_win    = enable && (row_idx == '0) && (dwell_cnt < TRI_END);
        sample_hit = enable && (row_idx == '0) && (dwell_cnt == SAMPLE_PT);

        row_onehot          = '0;
        row_onehot[row_idx] = 1'b1;
        col_slice           = row_data[row_idx*COL_W +: COL_W];
        seg_next            = hex_data[row_idx*SEG_W +: SEG_W];

        for (int c = 0; c < COL_W; c++)
            col_next[c] = (COL_REVERSE != 0) ? col_slice[COL_W-1-c] : col_slice[c];
        for (int i = 0; i < IO_W; i++) begin
            led_next[i]  = (IO_REVERSE != 0) ? led_data[IO_W-1-i] : led_data[i];
            gpio_next[i] = (IO_REVERSE != 0) ? gpio_in[IO_W-1-i]  : gpio_in[i];
        end

        // A differing sample restarts the stability run; a match extends it, saturating.
        if (gpio_next == last_sample) begin
            last_next   = last_sample;
            stable_next = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + SW'(1);
        end else begin
            last_next   = gpio_next;
            stable_next = '0;
        end
        commit = sample_hit && (stable_next == STABLE_MAX) &&
                 ((last_next != sw_out) || !sw_valid);
    end

    // led_oe resets low so the pins stay released while switches may be driving them.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            dwell_cnt   <= '0;
            row_idx     <= '0;
            last_sample <= '0;
            stable_cnt  <= '0;
            row_out     <= '0;
            col_out     <= '0;
            seg_out     <= '0;
            led_out     <= '0;
            led_oe      <= 1'b0;
            sw_out      <= '0;
            sw_valid    <= 1'b0;
            sw_changed  <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            if (enable) begin
                dwell_cnt <= dwell_wrap ? '0 : dwell_cnt + DW'(1);
                if (dwell_wrap)
                    row_idx <= row_wrap ? '0 : row_idx + RW'(1);
            end
            frame_tick <= enable && dwell_wrap && row_wrap;
            row_out    <= (enable && !blank) ? row_onehot : '0;
            col_out    <= col_next;
            seg_out    <= seg_next;
            led_oe     <= !tri_win;
            led_out    <= tri_win ? '0 : led_next;
            if (sample_hit) begin
                last_sample <= last_next;
                stable_cnt  <= stable_next;
            end
            sw_changed <= commit;
            if (commit) begin
                sw_out   <= last_next;
                sw_valid <= 1'b1;
            end
        end
    end

endmodule
